// File: rtl/lrhls_mac_pipe.sv
// Pipelined signed multiply-accumulate with valid/ready handshakes.
// Beats are summed until a beat flagged last; that beat emits one result.
module lrhls_mac_pipe #(
  parameter int A_WIDTH   = 18,
  parameter int B_WIDTH   = 18,
  parameter int ACC_WIDTH = 48,
  parameter int NUM_STAGE = 3,
  parameter int SAT       = 1
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [A_WIDTH-1:0]   din0,
  input  logic signed [B_WIDTH-1:0]   din1,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [ACC_WIDTH-1:0] dout,
  output logic                        dout_ovf
);

  localparam int unsigned P_WIDTH = A_WIDTH + B_WIDTH;
  localparam int unsigned S_WIDTH = ACC_WIDTH + 1;
  localparam int unsigned NS      = NUM_STAGE;

  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic                        ce;
  logic signed [P_WIDTH-1:0]   prod_in;
  logic signed [P_WIDTH-1:0]   prod_q [NS];
  logic [NS-1:0]               vld_q;
  logic [NS-1:0]               last_q;
  logic signed [ACC_WIDTH-1:0] acc_q;
  logic                        trk_q;
  logic signed [S_WIDTH-1:0]   sum;
  logic                        ovf;
  logic signed [ACC_WIDTH-1:0] sum_res;
  logic                        beat;

  // Whole pipeline advances only when the output register can take a result.
  assign ce       = !out_valid || out_ready;
  assign in_ready = ce;
  assign beat     = ce && vld_q[NS-1];

  // Full-precision signed product of the incoming operands.
  always_comb begin
    prod_in = $signed({{B_WIDTH{din0[A_WIDTH-1]}}, din0}) *
              $signed({{A_WIDTH{din1[B_WIDTH-1]}}, din1});
  end

  // Multiply pipeline: product, last flag and valid bit shift together.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      vld_q  <= '0;
      last_q <= '0;
      for (int unsigned i = 0; i < NS; i++) prod_q[i] <= '0;
    end else if (ce) begin
      vld_q[0]  <= in_valid;
      last_q[0] <= in_last;
      prod_q[0] <= prod_in;
      for (int unsigned i = 1; i < NS; i++) begin
        vld_q[i]  <= vld_q[i-1];
        last_q[i] <= last_q[i-1];
        prod_q[i] <= prod_q[i-1];
      end
    end
  end

  // Add the product into the running sum one bit wider than the accumulator,
  // then detect overflow and saturate or wrap.
  always_comb begin
    sum = $signed({{(S_WIDTH-P_WIDTH){prod_q[NS-1][P_WIDTH-1]}}, prod_q[NS-1]}) +
          $signed({acc_q[ACC_WIDTH-1], acc_q});
    ovf = sum[S_WIDTH-1] ^ sum[S_WIDTH-2];
    if (ovf && (SAT != 0)) sum_res = sum[S_WIDTH-1] ? ACC_MIN : ACC_MAX;
    else                   sum_res = sum[ACC_WIDTH-1:0];
  end

  // Accumulator and overflow tracker; a closing beat clears both for the next sum.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc_q <= '0;
      trk_q <= 1'b0;
    end else if (beat) begin
      if (last_q[NS-1]) begin
        acc_q <= '0;
        trk_q <= 1'b0;
      end else begin
        acc_q <= sum_res;
        trk_q <= trk_q | ovf;
      end
    end
  end

  // Output register: loads on a closing beat, otherwise drops valid after handshake.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_valid <= 1'b0;
      dout      <= '0;
      dout_ovf  <= 1'b0;
    end else if (ce) begin
      if (vld_q[NS-1] && last_q[NS-1]) begin
        out_valid <= 1'b1;
        dout      <= sum_res;
        dout_ovf  <= trk_q | ovf;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lrhls_mac_pipe.sv
// Self-checking bench for lrhls_mac_pipe: default config plus two 36-bit
// accumulator variants (saturating and wrapping) driven in lockstep.
module tb_lrhls_mac_pipe;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid;
  logic in_last;
  logic out_ready;
  logic signed [17:0] din0;
  logic signed [17:0] din1;

  logic in_ready_d, out_valid_d, ovf_d;
  logic signed [47:0] dout_d;
  logic in_ready_s, out_valid_s, ovf_s;
  logic signed [35:0] dout_s;
  logic in_ready_w, out_valid_w, ovf_w;
  logic signed [35:0] dout_w;

  typedef struct {
    longint d;
    bit     o;
  } exp_t;

  typedef struct {
    longint a;
    longint b;
    bit     last;
    longint exp_d;
    bit     exp_o;
  } vec_t;

  exp_t q_d[$];
  exp_t q_s[$];
  exp_t q_w[$];
  vec_t vecs[$];

  int n_cmp  = 0;
  int n_fail = 0;

  longint acc_s = 0;
  longint acc_w = 0;
  bit     trk_s = 1'b0;
  bit     trk_w = 1'b0;

  lrhls_mac_pipe #(.A_WIDTH(18), .B_WIDTH(18), .ACC_WIDTH(48), .NUM_STAGE(3), .SAT(1)) u_def (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_d),
    .din0(din0), .din1(din1), .in_last(in_last), .out_valid(out_valid_d),
    .out_ready(out_ready), .dout(dout_d), .dout_ovf(ovf_d)
  );

  lrhls_mac_pipe #(.A_WIDTH(18), .B_WIDTH(18), .ACC_WIDTH(36), .NUM_STAGE(3), .SAT(1)) u_sat (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .din0(din0), .din1(din1), .in_last(in_last), .out_valid(out_valid_s),
    .out_ready(out_ready), .dout(dout_s), .dout_ovf(ovf_s)
  );

  lrhls_mac_pipe #(.A_WIDTH(18), .B_WIDTH(18), .ACC_WIDTH(36), .NUM_STAGE(3), .SAT(0)) u_wrap (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
    .din0(din0), .din1(din1), .in_last(in_last), .out_valid(out_valid_w),
    .out_ready(out_ready), .dout(dout_w), .dout_ovf(ovf_w)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input longint got, input longint want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Reference accumulate step for a given width and overflow policy.
  task automatic mstep(input int w, input bit sat, input longint p, input bit last,
                       inout longint acc, inout bit trk, output longint res, output bit o);
    longint mx, mn, s, m;
    bit     ov;
    mx = (longint'(1) <<< (w - 1)) - 1;
    mn = -mx - 1;
    s  = acc + p;
    ov = (s > mx) || (s < mn);
    if (ov) begin
      if (sat) s = (s > mx) ? mx : mn;
      else begin
        m = longint'(1) <<< w;
        s = s & (m - 1);
        if (s > mx) s = s - m;
      end
    end
    res = s;
    o   = trk | ov;
    if (last) begin
      acc = 0;
      trk = 1'b0;
    end else begin
      acc = s;
      trk = o;
    end
  endtask

  // Present one beat, wait (bounded) for acceptance, then update scoreboards.
  task automatic send(input longint a, input longint b, input bit last,
                      input longint exp_d, input bit exp_o);
    int unsigned waited = 0;
    bit          ok = 1'b0;
    longint      r;
    bit          o;
    exp_t        e;
    din0     = a[17:0];
    din1     = b[17:0];
    in_last  = last;
    in_valid = 1'b1;
    while (!ok && waited < 200) begin
      @(negedge clk);
      if (in_ready_d) begin
        ok = 1'b1;
        @(posedge clk);
        #1;
      end else begin
        waited++;
      end
    end
    in_valid = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: beat (%0d,%0d) not accepted in 200 cycles", a, b);
    end else begin
      mstep(36, 1'b1, a * b, last, acc_s, trk_s, r, o);
      if (last) begin e.d = r; e.o = o; q_s.push_back(e); end
      mstep(36, 1'b0, a * b, last, acc_w, trk_w, r, o);
      if (last) begin e.d = r; e.o = o; q_w.push_back(e); end
      if (last) begin e.d = exp_d; e.o = exp_o; q_d.push_back(e); end
    end
  endtask

  task automatic drain();
    int unsigned waited = 0;
    while ((q_d.size() != 0 || q_s.size() != 0 || q_w.size() != 0) && waited < 100) begin
      @(posedge clk);
      waited++;
    end
    #1;
    check("pending_results", longint'(q_d.size() + q_s.size() + q_w.size()), 0);
  endtask

  initial begin
    exp_t   e;
    bit     hold_prev = 1'b0;
    longint prev_d = 0;
    int     lat;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    din0      = '0;
    din1      = '0;

    vecs.push_back('{2, 3, 1'b0, 0, 1'b0});
    vecs.push_back('{4, -1, 1'b0, 0, 1'b0});
    vecs.push_back('{-6, 7, 1'b0, 0, 1'b0});
    vecs.push_back('{10, 10, 1'b1, 60, 1'b0});
    vecs.push_back('{1, 1, 1'b1, 1, 1'b0});
    vecs.push_back('{-131072, -131072, 1'b1, 64'sd17179869184, 1'b0});
    vecs.push_back('{-131072, 131071, 1'b1, -64'sd17179738112, 1'b0});
    vecs.push_back('{-131072, -131072, 1'b0, 0, 1'b0});
    vecs.push_back('{-131072, -131072, 1'b0, 0, 1'b0});
    vecs.push_back('{-131072, -131072, 1'b0, 0, 1'b0});
    vecs.push_back('{-131072, -131072, 1'b1, 64'sd68719476736, 1'b0});
    vecs.push_back('{7, 8, 1'b1, 56, 1'b0});

    // Output monitor: pops scoreboards on handshake, checks hold stability.
    fork
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          hold_prev = 1'b0;
        end else begin
          if (hold_prev) check("dout_stable", longint'(dout_d), prev_d);
          check("valid_lockstep", {out_valid_s, out_valid_w}, {out_valid_d, out_valid_d});
          if (out_valid_d && out_ready) begin
            if (q_d.size() == 0 || q_s.size() == 0 || q_w.size() == 0) begin
              n_cmp++;
              n_fail++;
              $display("FAIL unexpected_output: got %0d, expected no result", longint'(dout_d));
            end else begin
              e = q_d.pop_front();
              check("dout_def", longint'(dout_d), e.d);
              check("ovf_def", longint'(ovf_d), longint'(e.o));
              e = q_s.pop_front();
              check("dout_sat36", longint'(dout_s), e.d);
              check("ovf_sat36", longint'(ovf_s), longint'(e.o));
              e = q_w.pop_front();
              check("dout_wrap36", longint'(dout_w), e.d);
              check("ovf_wrap36", longint'(ovf_w), longint'(e.o));
            end
          end
          hold_prev = out_valid_d && !out_ready;
          prev_d    = longint'(dout_d);
        end
      end
    join_none

    // Reset state
    #1;
    check("rst_out_valid", longint'(out_valid_d), 0);
    check("rst_dout", longint'(dout_d), 0);
    check("rst_ovf", longint'(ovf_d), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_in_ready", longint'(in_ready_d), 1);

    // Single-beat latency: accept edge plus NUM_STAGE further edges.
    send(3, -5, 1'b1, -15, 1'b0);
    lat = 0;
    while (!out_valid_d && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency_edges_after_accept", longint'(lat), 3);
    drain();

    // Table-driven sums, back-to-back
    for (int i = 0; i < vecs.size(); i++)
      send(vecs[i].a, vecs[i].b, vecs[i].last, vecs[i].exp_d, vecs[i].exp_o);
    drain();

    // Backpressure: three singles with out_ready low
    out_ready = 1'b0;
    send(2, 3, 1'b1, 6, 1'b0);
    send(-4, 5, 1'b1, -20, 1'b0);
    send(6, 6, 1'b1, 36, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    check("bp_in_ready_low", longint'(in_ready_d), 0);
    check("bp_out_valid", longint'(out_valid_d), 1);
    check("bp_first_held", longint'(dout_d), 6);
    out_ready = 1'b1;
    drain();

    // Reset mid-sum with a result parked in the output register
    out_ready = 1'b0;
    send(7, 3, 1'b1, 21, 1'b0);
    send(9, 9, 1'b0, 0, 1'b0);
    send(4, 4, 1'b0, 0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check("pre_reset_parked", longint'(dout_d), 21);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", longint'(out_valid_d), 0);
    check("async_rst_dout", longint'(dout_d), 0);
    check("async_rst_dout_s", longint'(dout_s), 0);
    q_d.delete();
    q_s.delete();
    q_w.delete();
    acc_s = 0; trk_s = 1'b0;
    acc_w = 0; trk_w = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    send(5, 5, 1'b1, 25, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lrhls_mac_pipe.md
Name: lrhls_mac_pipe

Overview:
- Parametrised, pipelined signed multiply-accumulate unit with valid/ready handshakes on input and output. Successor to the fixed 18x18 combinational multiplier cores.
- Used by the LRHLS datapath for dot-product and sum-of-products terms in the linear-regression fit.
- Each input beat is one operand pair. Consecutive beats are summed until a beat marked last, which produces one output word.
- A lone beat with last=1 is a plain registered multiply.

Parameters:
- A_WIDTH, 18, width of signed operand din0
- B_WIDTH, 18, width of signed operand din1
- ACC_WIDTH, 48, accumulator and output width; must be >= A_WIDTH+B_WIDTH
- NUM_STAGE, 3, multiply pipeline register stages, >= 1
- SAT, 1, 1 = saturate accumulator on overflow, 0 = two's-complement wrap

Ports:
- ap_clk  in  1  clock; all state changes on the rising edge
- ap_rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- din0  in  A_WIDTH  signed operand A
- din1  in  B_WIDTH  signed operand B
- in_last  in  1  beat closes the current sum
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- dout  out  ACC_WIDTH  signed sum of products
- dout_ovf  out  1  overflow occurred anywhere in this sum

Behaviour:
- Reset (async assert, sync release): all stage valid bits = 0, accumulator = 0, ovf tracker = 0, out_valid = 0, dout = 0, dout_ovf = 0.
- Reset mid-sum discards the partial sum and all in-flight beats.
- Global advance enable: ce = !out_valid || out_ready.
- in_ready = ce. It is combinational from out_ready; no combinational path from in_valid.
- When ce = 0, every pipeline register, valid bit, accumulator and output register holds.
- Multiply pipeline: the accepted beat (operands, last flag, valid=1) enters stage 1. The full-precision product A_WIDTH+B_WIDTH is available after stage NUM_STAGE.
  - Retiming between stages is free.
  - When in_valid=0 and ce=1, a bubble (valid=0) enters.
- Accumulate stage, active when ce=1 and the stage-NUM_STAGE valid bit = 1:
  - sum = base + sign-extended product, computed in ACC_WIDTH+1 bits.
  - base = accumulator, or 0 if the previous valid beat had last=1 or there has been no beat since reset.
  - Overflow = sum outside [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
  - SAT=1: clamp to the nearer bound. SAT=0: keep the low ACC_WIDTH bits.
  - Overflow ORs into the ovf tracker. The tracker starts from 0 at the first beat of each sum.
- Beat with last=0: accumulator <= sum; no output.
- Beat with last=1: out_valid <= 1, dout <= sum, dout_ovf <= tracker | this beat's overflow. Accumulator and tracker are then cleared for the next sum.
- Output register: out_valid drops after the handshake unless a new result loads in the same cycle. dout and dout_ovf are stable while out_valid=1 && out_ready=0.
- Latency: accepted last beat -> out_valid is NUM_STAGE+1 cycles with no backpressure. Throughput is 1 beat/cycle with no backpressure.
- Bubbles between beats of one sum do not break the sum; only last terminates it.
- Simultaneous output handshake and new result in the same cycle: the new result loads, out_valid stays 1, nothing is lost.
- Arithmetic is signed throughout. The most-negative x most-negative product is exact because the product width is A_WIDTH+B_WIDTH.

Test Plan:
- Defaults. Single beat din0=3, din1=-5, last=1 at cycle 0, out_ready=1 -> out_valid in cycle 4, dout=-15, dout_ovf=0.
- Four-beat sum (2,3),(4,-1),(-6,7),(10,10), last on the 4th beat, back-to-back -> exactly one output, dout=6-4-42+100=60. Then a following single beat (1,1,last) -> dout=1, confirming the clear.
- Extremes. (-131072,-131072,last) -> dout=17179869184. (-131072,131071,last) -> dout=-17179738112.
- ACC_WIDTH=36, SAT=1: four beats (-131072,-131072), last on the 4th -> dout=34359738367, dout_ovf=1. Same with SAT=0 -> dout=0 (2^36 wraps), dout_ovf=1. A following clean sum gives dout_ovf=0.
- Backpressure. Stream 3 single-beat multiplies with out_ready=0 -> the first result is held stable, in_ready falls once the pipeline is full, no beat is lost. Raise out_ready -> results appear in order with correct values.
- Reset mid-sum. Two beats of a sum accepted, ap_rst_n pulsed low asynchronously -> outputs clear immediately. A new (5,5,last) -> dout=25 with no residue from the old sum.
